// File: rtl/float_rounder_pipe_if.sv
// Handshake bundle for float_rounder_pipe: input transaction, result and
// both valid/ready pairs. Master is the producer/consumer side, slave is the
// rounder itself.
interface float_rounder_pipe_if #(parameter int N = 4);
  logic         in_valid;
  logic         in_ready;
  logic         sign;
  logic [N-1:0] A;
  logic [1:0]   sticky;
  logic [2:0]   round_mode;
  logic [2:0]   frm;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   Y;
  logic         inexact;
  logic         invalid_rm;

  modport master (
    output in_valid, sign, A, sticky, round_mode, frm, out_ready,
    input  in_ready, out_valid, Y, inexact, invalid_rm
  );

  modport slave (
    input  in_valid, sign, A, sticky, round_mode, frm, out_ready,
    output in_ready, out_valid, Y, inexact, invalid_rm
  );
endinterface

// File: rtl/float_rounder_pipe.sv
// Rounding-increment stage with a valid/ready output register.
// The rounding decision is combinational on the accepted input; the result
// is registered, giving one cycle of latency when the output stage is free.
// Build option FLOAT_ROUNDER_PIPE_SKID_EN adds a second (skid) entry so that
// in_ready comes straight from a flop instead of from out_ready.
module float_rounder_pipe #(
  parameter int N = 4
) (
  input logic                  clock,
  input logic                  reset,
  float_rounder_pipe_if.slave  bus
);
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_DYN = 3'd7;

  // result word: {Y, inexact, invalid_rm}
  localparam int RW = N + 3;

  logic [2:0]    w_eff;
  logic          w_legal;
  logic          w_inc;
  logic          w_any;
  logic [N:0]    w_y;
  logic [RW-1:0] w_res;
  logic          w_in_fire;
  logic          w_out_fire;

  // Effective mode and increment decision; illegal modes pass A through.
  always_comb begin
    w_eff   = (bus.round_mode == RM_DYN) ? bus.frm : bus.round_mode;
    w_legal = (w_eff <= RM_RMM);
    w_any   = |bus.sticky;
    w_inc   = 1'b0;
    case (w_eff)
      RM_RNE:  w_inc = bus.sticky[1] & (bus.sticky[0] | bus.A[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = bus.sign & w_any;
      RM_RUP:  w_inc = ~bus.sign & w_any;
      RM_RMM:  w_inc = bus.sticky[1];
      default: w_inc = 1'b0;
    endcase
    w_y   = {1'b0, bus.A} + {{N{1'b0}}, w_inc & w_legal};
    w_res = {w_y, w_legal & w_any, ~w_legal};
  end

  logic          r_out_vld;
  logic [RW-1:0] r_out;

  assign w_out_fire     = r_out_vld & bus.out_ready;
  assign bus.out_valid  = r_out_vld;
  assign bus.Y          = r_out[RW-1:2];
  assign bus.inexact    = r_out[1];
  assign bus.invalid_rm = r_out[0];

`ifdef FLOAT_ROUNDER_PIPE_SKID_EN
  logic          r_skd_vld;
  logic [RW-1:0] r_skd;
  logic          r_in_rdy;

  assign bus.in_ready = r_in_rdy;
  assign w_in_fire    = bus.in_valid & r_in_rdy;

  // Output register plus skid entry. in_ready is the registered "skid empty"
  // flag, so a stalled consumer only blocks input once both entries hold data.
  // The skid entry always drains into the output register before new input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
      r_skd_vld <= 1'b0;
      r_skd     <= '0;
      r_in_rdy  <= 1'b0;
    end else begin
      r_in_rdy <= 1'b1;
      if (r_skd_vld) begin
        if (w_out_fire) begin
          r_out     <= r_skd;
          r_skd_vld <= 1'b0;
        end else begin
          r_in_rdy  <= 1'b0;
        end
      end else if (w_in_fire) begin
        if (!r_out_vld || bus.out_ready) begin
          r_out     <= w_res;
          r_out_vld <= 1'b1;
        end else begin
          r_skd     <= w_res;
          r_skd_vld <= 1'b1;
          r_in_rdy  <= 1'b0;
        end
      end else if (w_out_fire) begin
        r_out_vld <= 1'b0;
      end
    end
  end
`else
  assign bus.in_ready = ~r_out_vld | bus.out_ready;
  assign w_in_fire    = bus.in_valid & bus.in_ready;

  // Single output register: load on accept (replacing a result leaving the
  // same cycle), otherwise empty once the consumer takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else if (w_in_fire) begin
      r_out_vld <= 1'b1;
      r_out     <= w_res;
    end else if (bus.out_ready) begin
      r_out_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_float_rounder_pipe.sv
// Directed bench for float_rounder_pipe (N=4): hand-computed vectors,
// a mode sweep against a scoreboard, backpressure and reset cases.
module tb_float_rounder_pipe;
  localparam int N = 4;

  typedef struct packed {
    logic       sign;
    logic [3:0] a;
    logic [1:0] sticky;
    logic [2:0] rm;
    logic [2:0] frm;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nin = 0, nout = 0;
  logic [6:0] q[$];

  always #5 clock = ~clock;

  float_rounder_pipe_if #(.N(N)) ifc ();
  float_rounder_pipe #(.N(N)) dut (.clock(clock), .reset(reset), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rounding: returns {Y[4:0], inexact, invalid_rm}.
  function automatic logic [6:0] model(input vec_t v);
    logic [2:0] eff;
    logic       inc;
    logic [4:0] y;
    eff = (v.rm == 3'd7) ? v.frm : v.rm;
    if (eff > 3'd4) return {1'b0, v.a, 1'b0, 1'b1};
    case (eff)
      3'd0: inc = (v.sticky == 2'b11) || (v.sticky == 2'b10 && v.a[0]);
      3'd2: inc = v.sign && (v.sticky != 2'b00);
      3'd3: inc = !v.sign && (v.sticky != 2'b00);
      3'd4: inc = (v.sticky >= 2'b10);
      default: inc = 1'b0;
    endcase
    y = {1'b0, v.a} + 5'(inc);
    return {y, v.sticky != 2'b00, 1'b0};
  endfunction

  // One cycle: drive at negedge, sample #1 later, score both handshakes.
  task automatic tick(input bit rdy, input bit have, input vec_t v, output bit acc);
    @(negedge clock);
    ifc.out_ready  = rdy;
    ifc.in_valid   = have;
    ifc.sign       = v.sign;
    ifc.A          = v.a;
    ifc.sticky     = v.sticky;
    ifc.round_mode = v.rm;
    ifc.frm        = v.frm;
    #1;
    acc = ifc.in_valid && ifc.in_ready;
    if (ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) chk("spurious_out", ifc.out_valid, 1'b0);
      else chk("result", {ifc.Y, ifc.inexact, ifc.invalid_rm}, q.pop_front());
      nout++;
    end
    if (acc) begin
      q.push_back(model(v));
      nin++;
    end
  endtask

  task automatic directed(input string tag, input vec_t v, input logic [4:0] ey,
                          input logic ei, input logic eiv);
    bit acc;
    tick(1'b1, 1'b1, v, acc);
    chk({tag, "_acc"}, acc, 1'b1);
    tick(1'b1, 1'b0, v, acc);
    chk({tag, "_ovld"}, ifc.out_valid, 1'b1);
    chk({tag, "_y"}, ifc.Y, ey);
    chk({tag, "_inexact"}, ifc.inexact, ei);
    chk({tag, "_invalid"}, ifc.invalid_rm, eiv);
  endtask

  vec_t idle, sw[$], bp[3];

  initial begin
    bit acc;
    int idx, sent, sz, cyc;
    idle = '0;
    reset = 1'b1;
    ifc.in_valid = 0; ifc.out_ready = 0; ifc.sign = 0; ifc.A = 0;
    ifc.sticky = 0; ifc.round_mode = 0; ifc.frm = 0;
    #1;
    chk("rst_ovld", ifc.out_valid, 1'b0);
    chk("rst_y", ifc.Y, 5'd0);
    chk("rst_inexact", ifc.inexact, 1'b0);
    chk("rst_invalid", ifc.invalid_rm, 1'b0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    tick(1'b1, 1'b0, idle, acc);
    chk("post_rst_inready", ifc.in_ready, 1'b1);
    chk("post_rst_ovld", ifc.out_valid, 1'b0);

    // Hand-computed vectors
    directed("rne_tie", '{sign:0, a:4'b0101, sticky:2'b10, rm:3'd0, frm:3'd0}, 5'b00110, 1, 0);
    directed("rup_carry", '{sign:0, a:4'b1111, sticky:2'b11, rm:3'd3, frm:3'd0}, 5'b10000, 1, 0);
    directed("dyn_rdn", '{sign:1, a:4'b0011, sticky:2'b01, rm:3'd7, frm:3'd2}, 5'b00100, 1, 0);
    directed("dyn_bad", '{sign:1, a:4'b0011, sticky:2'b01, rm:3'd7, frm:3'd6}, 5'b00011, 0, 1);
    directed("rm_5", '{sign:0, a:4'b1010, sticky:2'b11, rm:3'd5, frm:3'd0}, 5'b01010, 0, 1);
    directed("dyn_dyn", '{sign:0, a:4'b0110, sticky:2'b10, rm:3'd7, frm:3'd7}, 5'b00110, 0, 1);
    directed("rtz", '{sign:0, a:4'b0111, sticky:2'b11, rm:3'd1, frm:3'd0}, 5'b00111, 1, 0);
    directed("rmm", '{sign:1, a:4'b0100, sticky:2'b10, rm:3'd4, frm:3'd0}, 5'b00101, 1, 0);
    directed("rne_even", '{sign:0, a:4'b0100, sticky:2'b10, rm:3'd0, frm:3'd0}, 5'b00100, 1, 0);
    directed("rdn_pos", '{sign:0, a:4'b0100, sticky:2'b11, rm:3'd2, frm:3'd0}, 5'b00100, 1, 0);
    tick(1'b1, 1'b0, idle, acc);

    // Sweep of all A/sticky/sign over modes 0-4 with random out_ready
    for (int m = 0; m < 5; m++)
      for (int s = 0; s < 2; s++)
        for (int a = 0; a < 16; a++)
          for (int k = 0; k < 4; k++)
            sw.push_back('{sign:s[0], a:a[3:0], sticky:k[1:0], rm:m[2:0], frm:3'd0});
    nin = 0; nout = 0; idx = 0; cyc = 0;
    while ((idx < sw.size() || q.size() != 0) && cyc < 3000) begin
      tick(1'($urandom_range(0, 1)), idx < sw.size(), (idx < sw.size()) ? sw[idx] : idle, acc);
      if (acc) idx++;
      cyc++;
    end
    chk("sweep_sent", idx, sw.size());
    chk("sweep_count", nout, nin);

    // Backpressure: three back-to-back inputs, consumer stalled 4 cycles
    bp[0] = '{sign:0, a:4'd1, sticky:2'b00, rm:3'd1, frm:3'd0};
    bp[1] = '{sign:0, a:4'd2, sticky:2'b00, rm:3'd1, frm:3'd0};
    bp[2] = '{sign:0, a:4'd3, sticky:2'b00, rm:3'd1, frm:3'd0};
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      sz = q.size();
      tick(1'b0, sent < 3, (sent < 3) ? bp[sent] : idle, acc);
`ifdef FLOAT_ROUNDER_PIPE_SKID_EN
      chk("bp_inready", ifc.in_ready, sz < 2);
`else
      chk("bp_inready", ifc.in_ready, sz == 0);
`endif
      if (sz > 0) begin
        chk("bp_ovld", ifc.out_valid, 1'b1);
        chk("bp_hold_y", ifc.Y, 5'd1);
      end
      if (acc) sent++;
    end
    cyc = 0;
    while ((sent < 3 || q.size() != 0) && cyc < 20) begin
      tick(1'b1, sent < 3, (sent < 3) ? bp[sent] : idle, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("bp_sent", sent, 3);
    chk("bp_drained", q.size(), 0);

    // Reset while a result is held
    tick(1'b0, 1'b1, bp[2], acc);
    tick(1'b0, 1'b0, idle, acc);
    chk("pre_rst_ovld", ifc.out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_ovld", ifc.out_valid, 1'b0);
    chk("midrst_y", ifc.Y, 5'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b0, idle, acc);
      chk("no_stale_ovld", ifc.out_valid, 1'b0);
    end
    chk("post_rst2_inready", ifc.in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
